// File: rtl/parity_pkg.sv
// Shared types and helpers for the serial parity checker.
package parity_pkg;

    // Frame receive states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_e;

    // Parity mode encodings as sampled from inMode on the start cycle.
    localparam logic MODE_EVEN = 1'b0;
    localparam logic MODE_ODD  = 1'b1;

    // Parity error for a completed frame.
    // data_xor is the xor of all data bits, par_bit the received parity bit.
    // The total xor must be 0 in even mode and 1 in odd mode.
    function automatic logic parity_error(
        input logic data_xor,
        input logic par_bit,
        input logic mode
    );
        logic total_s;
        total_s = data_xor ^ par_bit;
        if (mode == MODE_ODD) begin
            return (total_s != 1'b1);
        end else begin
            return (total_s != 1'b0);
        end
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// A clear coinciding with an increment yields 1 (clear first, then count).
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inInc,
    input  logic         inClr,
    output logic [W-1:0] outCnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear has priority, then saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (inClr) begin
            if (inInc) begin
                cnt_d = CNT_ONE;
            end else begin
                cnt_d = '0;
            end
        end else if (inInc) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign outCnt = cnt_q;

endmodule

// File: rtl/serial_parity_checker.sv
// Serial parity checker: receives DATA_W data bits LSB first followed by one
// parity bit, reports the captured word, a done pulse, a parity error flag and
// a saturating count of errored frames. A new start aborts any open frame.
module serial_parity_checker
    import parity_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inStart,
    input  logic                 inMode,
    input  logic                 inValid,
    input  logic                 inBit,
    input  logic                 inClrCnt,
    output logic                 outBusy,
    output logic                 outDone,
    output logic                 outPEC,
    output logic [DATA_W-1:0]    outData,
    output logic [ERR_CNT_W-1:0] outErrCnt,
    output logic                 outAbort
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    // Frame tracking state.
    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                xor_q, xor_d;
    logic                mode_q, mode_d;

    // Registered outputs.
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                abort_q, abort_d;
    logic                pec_q, pec_d;
    logic [DATA_W-1:0]   data_q, data_d;

    // Frame completion qualifiers feeding the error counter.
    logic                complete_s;
    logic                frame_err_s;
    logic                cnt_inc_s;

    // Next-state and next-output logic for the frame FSM.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        xor_d       = xor_q;
        mode_d      = mode_q;
        done_d      = 1'b0;
        abort_d     = 1'b0;
        pec_d       = pec_q;
        data_d      = data_q;
        complete_s  = 1'b0;
        frame_err_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (inStart) begin
                    state_d = DATA;
                    mode_d  = inMode;
                    idx_d   = '0;
                    shift_d = '0;
                    xor_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end

            DATA: begin
                if (inStart) begin
                    // Abandon the open frame and restart with a fresh mode.
                    abort_d = 1'b1;
                    state_d = DATA;
                    mode_d  = inMode;
                    idx_d   = '0;
                    shift_d = '0;
                    xor_d   = 1'b0;
                end else if (inValid) begin
                    shift_d[idx_q] = inBit;
                    xor_d          = xor_q ^ inBit;
                    if (idx_q == LAST_IDX) begin
                        state_d = PAR;
                        idx_d   = idx_q;
                    end else begin
                        state_d = DATA;
                        idx_d   = idx_q + IDX_ONE;
                    end
                end else begin
                    state_d = DATA;
                end
            end

            PAR: begin
                if (inStart) begin
                    // Start beats a simultaneous parity bit: abort, no done.
                    abort_d = 1'b1;
                    state_d = DATA;
                    mode_d  = inMode;
                    idx_d   = '0;
                    shift_d = '0;
                    xor_d   = 1'b0;
                end else if (inValid) begin
                    complete_s  = 1'b1;
                    frame_err_s = parity_error(xor_q, inBit, mode_q);
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    data_d      = shift_q;
                    pec_d       = frame_err_s;
                end else begin
                    state_d = PAR;
                end
            end

            default: begin
                state_d = IDLE;
                idx_d   = '0;
                shift_d = '0;
                xor_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign cnt_inc_s = complete_s & frame_err_s;

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            xor_q   <= 1'b0;
            mode_q  <= MODE_EVEN;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            pec_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            xor_q   <= xor_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            pec_q   <= pec_d;
            data_q  <= data_d;
        end
    end

    sat_counter #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inInc  (cnt_inc_s),
        .inClr  (inClrCnt),
        .outCnt (outErrCnt)
    );

    assign outBusy  = busy_q;
    assign outDone  = done_q;
    assign outAbort = abort_q;
    assign outPEC   = pec_q;
    assign outData  = data_q;

endmodule
